// File: rtl/rr_trace_marshaller2_pkg.sv
// rr_pkg: shared channel-width constants and the width-sum helper for the marshaller tree
package rr_pkg;
  localparam int RR_CHANNEL_WIDTH_BITS = 8;
  localparam int RR_MAX_CH = 16;
  typedef logic [RR_MAX_CH-1:0][RR_CHANNEL_WIDTH_BITS-1:0] rr_widths_t;
  typedef logic [RR_MAX_CH-1:0] rr_mask_t;
  function automatic int unsigned rr_sum_widths(input rr_widths_t w, input rr_mask_t m);
    int unsigned s;
    s = 0;
    for (int i = 0; i < RR_MAX_CH; i++)
      if (m[i]) s += 32'(w[i]);
    return s;
  endfunction
endpackage

// File: rtl/rr_trace_marshaller2_if.sv
// rr_trace_marshaller2_if: child A/B input fields, parent output stream and status flags
interface rr_trace_marshaller2_if #(
  parameter int LEFT_CNT = 2,
  parameter int RIGHT_CNT = 2,
  parameter int LEFT_W = 24,
  parameter int RIGHT_W = 36,
  parameter int LOGE_A_CNT = 2,
  parameter int LOGE_B_CNT = 2
);
  localparam int DATA_W = LEFT_W + RIGHT_W;
  logic a_valid;
  logic [LEFT_CNT-1:0] a_logb_valid;
  logic [LEFT_W-1:0] a_logb_data;
  logic [LOGE_A_CNT-1:0] a_loge_valid;
  logic b_valid;
  logic [RIGHT_CNT-1:0] b_logb_valid;
  logic [RIGHT_W-1:0] b_logb_data;
  logic [LOGE_B_CNT-1:0] b_loge_valid;
  logic almful;
  logic out_valid;
  logic out_ready;
  logic [LEFT_CNT+RIGHT_CNT-1:0] out_logb_valid;
  logic [LOGE_A_CNT+LOGE_B_CNT-1:0] out_loge_valid;
  logic [DATA_W-1:0] out_logb_data;
  logic mismatch_err;
  logic overflow_err;
  modport master (
    output a_valid, a_logb_valid, a_logb_data, a_loge_valid,
    output b_valid, b_logb_valid, b_logb_data, b_loge_valid, out_ready,
    input almful, out_valid, out_logb_valid, out_loge_valid, out_logb_data, mismatch_err, overflow_err
  );
  modport slave (
    input a_valid, a_logb_valid, a_logb_data, a_loge_valid,
    input b_valid, b_logb_valid, b_logb_data, b_loge_valid, out_ready,
    output almful, out_valid, out_logb_valid, out_loge_valid, out_logb_data, mismatch_err, overflow_err
  );
endinterface

// File: rtl/rr_trace_marshaller2_fifo.sv
// rr_marshal_fifo: first-word fall-through FIFO with occupancy count and registered almost-full
module rr_marshal_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int SLACK = 3,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
)(
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [WIDTH-1:0] din,
  input  logic pop,
  output logic [WIDTH-1:0] dout,
  output logic valid,
  output logic [CW-1:0] count,
  output logic almful
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_pop, do_push;
  logic [CW-1:0] count_nxt;
  assign valid = count != '0;
  assign dout = mem[rd];
  assign do_pop = pop & valid;
  // a full FIFO still accepts a write when the head leaves in the same cycle
  assign do_push = push & (count != CW'(DEPTH) | do_pop);
  assign count_nxt = count + CW'(do_push) - CW'(do_pop);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      almful <= 1'b0;
    end else begin
      rd <= rd + AW'(do_pop);
      wr <= wr + AW'(do_push);
      count <= count_nxt;
      almful <= count_nxt >= CW'(DEPTH - SLACK);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
endmodule

// File: rtl/rr_trace_marshaller2.sv
// rr_trace_marshaller2: joins child packets A and B into one compacted packet through a 2-stage pipe and output FIFO
module rr_trace_marshaller2
  import rr_pkg::*;
#(
  parameter int LEFT_CNT = 2,
  parameter int RIGHT_CNT = 2,
  parameter logic [LEFT_CNT+RIGHT_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS = {8'd4, 8'd32, 8'd8, 8'd16},
  parameter int LOGE_A_CNT = 2,
  parameter int LOGE_B_CNT = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int ALMFUL_SLACK = 3
)(
  input logic clk,
  input logic rst,
  rr_trace_marshaller2_if.slave bus
);
  localparam int CH = LEFT_CNT + RIGHT_CNT;
  localparam rr_widths_t WPAD = rr_widths_t'(CHANNEL_WIDTHS);
  localparam int LEFT_W = rr_sum_widths(WPAD, rr_mask_t'((1 << LEFT_CNT) - 1));
  localparam int RIGHT_W = rr_sum_widths(WPAD, rr_mask_t'(((1 << CH) - 1) ^ ((1 << LEFT_CNT) - 1)));
  localparam int DATA_W = LEFT_W + RIGHT_W;
  localparam int LEN_W = $clog2(LEFT_W + 1);
  localparam int LE_W = LOGE_A_CNT + LOGE_B_CNT;
  localparam int WORD_W = LE_W + CH + DATA_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic s1_valid, s2_valid, mismatch_q, overflow_q, ovf, fifo_valid;
  logic [LEFT_CNT-1:0] s1_alv;
  logic [LEFT_W-1:0] s1_ad;
  logic [LOGE_A_CNT-1:0] s1_ale;
  logic [RIGHT_CNT-1:0] s1_blv;
  logic [RIGHT_W-1:0] s1_bd;
  logic [LOGE_B_CNT-1:0] s1_ble;
  logic [LEN_W-1:0] s1_len;
  logic [DATA_W-1:0] packed_data;
  logic [WORD_W-1:0] s2_word, fifo_dout;
  logic [CW-1:0] fifo_count;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      mismatch_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      s1_valid <= bus.a_valid | bus.b_valid;
      s2_valid <= s1_valid;
      mismatch_q <= mismatch_q | (bus.a_valid ^ bus.b_valid);
      overflow_q <= overflow_q | ovf;
    end
  // an absent side of a mismatched beat contributes nothing
  always_ff @(posedge clk) begin
    s1_alv <= bus.a_valid ? bus.a_logb_valid : '0;
    s1_ad <= bus.a_valid ? bus.a_logb_data : '0;
    s1_ale <= bus.a_valid ? bus.a_loge_valid : '0;
    s1_blv <= bus.b_valid ? bus.b_logb_valid : '0;
    s1_bd <= bus.b_valid ? bus.b_logb_data : '0;
    s1_ble <= bus.b_valid ? bus.b_loge_valid : '0;
    s1_len <= bus.a_valid ? LEN_W'(rr_sum_widths(WPAD, rr_mask_t'(bus.a_logb_valid))) : '0;
    s2_word <= {s1_ble, s1_ale, s1_blv, s1_alv, packed_data};
  end
  assign packed_data = DATA_W'(s1_ad & ~({LEFT_W{1'b1}} << s1_len)) | (DATA_W'(s1_bd) << s1_len);
  // when full the head is always valid, so the pop side is just out_ready
  assign ovf = s2_valid & (fifo_count == CW'(FIFO_DEPTH)) & ~bus.out_ready;
  rr_marshal_fifo #(
    .WIDTH(WORD_W),
    .DEPTH(FIFO_DEPTH),
    .SLACK(ALMFUL_SLACK)
  ) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(s2_valid),
    .din(s2_word),
    .pop(bus.out_ready),
    .dout(fifo_dout),
    .valid(fifo_valid),
    .count(fifo_count),
    .almful(bus.almful)
  );
  assign bus.out_valid = fifo_valid;
  assign {bus.out_loge_valid, bus.out_logb_valid, bus.out_logb_data} = fifo_valid ? fifo_dout : '0;
  assign bus.mismatch_err = mismatch_q;
  assign bus.overflow_err = overflow_q;
endmodule

// File: tb/tb_rr_trace_marshaller2.sv
// tb_rr_trace_marshaller2: scoreboard bench with a behavioural packing model and random streams
module tb_rr_trace_marshaller2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rr_trace_marshaller2_if #(
    .LEFT_CNT(2), .RIGHT_CNT(2), .LEFT_W(24), .RIGHT_W(36), .LOGE_A_CNT(2), .LOGE_B_CNT(2)
  ) bus ();
  rr_trace_marshaller2 dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [3:0] lv;
    logic [3:0] le;
    logic [59:0] d;
  } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int W[4] = '{16, 8, 32, 4};
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic exp_t model(input bit av, input bit bv, input logic [1:0] alv, input logic [23:0] ad,
                                 input logic [1:0] ale, input logic [1:0] blv, input logic [35:0] bd,
                                 input logic [1:0] ble);
    exp_t e;
    int la;
    logic [127:0] m;
    if (!av) begin alv = '0; ad = '0; ale = '0; end
    if (!bv) begin blv = '0; bd = '0; ble = '0; end
    la = 0;
    for (int i = 0; i < 2; i++) if (alv[i]) la += W[i];
    m = (128'(ad) % (128'd1 << la)) + (128'(bd) * (128'd1 << la));
    e.d = m[59:0];
    e.lv = {blv, alv};
    e.le = {ble, ale};
    return e;
  endfunction
  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic beat(input bit av, input bit bv, input logic [1:0] alv, input logic [23:0] ad,
                      input logic [1:0] ale, input logic [1:0] blv, input logic [35:0] bd,
                      input logic [1:0] ble, input bit keep);
    bus.a_valid = av; bus.a_logb_valid = alv; bus.a_logb_data = ad; bus.a_loge_valid = ale;
    bus.b_valid = bv; bus.b_logb_valid = blv; bus.b_logb_data = bd; bus.b_loge_valid = ble;
    if (keep) q.push_back(model(av, bv, alv, ad, ale, blv, bd, ble));
    cycles(1);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
  endtask
  task automatic rand_beat(input bit keep);
    logic [1:0] blv;
    logic [63:0] bd;
    int lb;
    blv = 2'($urandom);
    lb = 0;
    for (int i = 0; i < 2; i++) if (blv[i]) lb += W[2+i];
    bd = {$urandom, $urandom} & ((64'd1 << lb) - 1);
    beat(1'b1, 1'b1, 2'($urandom), 24'($urandom), 2'($urandom), blv, bd[35:0], 2'($urandom), keep);
  endtask
  task automatic drain(input string name);
    int t;
    t = 0;
    bus.out_ready = 1'b1;
    while (q.size() > 0 && t < 300) begin cycles(1); t++; end
    chk(name, 64'(q.size()), 64'd0);
    cycles(2);
    chk({name, "_empty"}, 64'(bus.out_valid), 64'd0);
  endtask
  task automatic wait_out(input string name, input logic [3:0] lv, input logic [3:0] le, input logic [59:0] d);
    int t;
    t = 0;
    while (!bus.out_valid && t < 10) begin cycles(1); t++; end
    chk({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({name, "_lv"}, 64'(bus.out_logb_valid), 64'(lv));
    chk({name, "_le"}, 64'(bus.out_loge_valid), 64'(le));
    chk({name, "_data"}, 64'(bus.out_logb_data), 64'(d));
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
          else begin
            e = q.pop_front();
            chk("sb_lv", 64'(bus.out_logb_valid), 64'(e.lv));
            chk("sb_le", 64'(bus.out_loge_valid), 64'(e.le));
            chk("sb_data", 64'(bus.out_logb_data), 64'(e.d));
          end
        end else if (!bus.out_valid) begin
          chk("idle_data", 64'(bus.out_logb_data), 64'd0);
          chk("idle_flags", 64'({bus.out_loge_valid, bus.out_logb_valid}), 64'd0);
        end
      end
    end
  end
  initial begin
    int n;
    bus.a_valid = 1'b0; bus.a_logb_valid = '0; bus.a_logb_data = '0; bus.a_loge_valid = '0;
    bus.b_valid = 1'b0; bus.b_logb_valid = '0; bus.b_logb_data = '0; bus.b_loge_valid = '0;
    bus.out_ready = 1'b1;
    cycles(1);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_almful", 64'(bus.almful), 64'd0);
    chk("rst_mismatch", 64'(bus.mismatch_err), 64'd0);
    chk("rst_overflow", 64'(bus.overflow_err), 64'd0);
    rst = 1'b0;
    cycles(1);
    beat(1'b1, 1'b1, 2'b10, 24'hAB, 2'b00, 2'b01, 36'hDEADBEEF, 2'b00, 1'b1);
    chk("lat_1", 64'(bus.out_valid), 64'd0);
    cycles(1);
    chk("lat_2", 64'(bus.out_valid), 64'd0);
    cycles(1);
    chk("lat_3", 64'(bus.out_valid), 64'd1);
    chk("single_data", 64'(bus.out_logb_data), 64'hDEADBEEFAB);
    chk("single_lv", 64'(bus.out_logb_valid), 64'b0110);
    cycles(3);
    beat(1'b1, 1'b1, 2'b01, 24'hFF1234, 2'b00, 2'b11, 36'h987654321, 2'b00, 1'b1);
    wait_out("mask", 4'b1101, 4'b0000, 60'h9876543211234);
    cycles(3);
    beat(1'b1, 1'b1, 2'b00, 24'h55AA55, 2'b01, 2'b00, 36'h0, 2'b10, 1'b1);
    wait_out("loge_only", 4'b0000, 4'b1001, 60'h0);
    cycles(3);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) bus.out_ready = 1'($urandom);
      if (bus.almful || $urandom_range(3) == 0) cycles(1);
      else rand_beat(1'b1);
    end
    drain("rand_drain");
    chk("rand_overflow", 64'(bus.overflow_err), 64'd0);
    chk("rand_mismatch", 64'(bus.mismatch_err), 64'd0);
    bus.out_ready = 1'b0;
    n = 0;
    while (!bus.almful && n < 20) begin rand_beat(1'b1); n++; end
    chk("bp_beats_to_almful", 64'(n), 64'd7);
    cycles(6);
    chk("bp_almful", 64'(bus.almful), 64'd1);
    chk("bp_overflow", 64'(bus.overflow_err), 64'd0);
    chk("bp_held", 64'(bus.out_valid), 64'd1);
    drain("bp_drain");
    chk("bp_almful_drop", 64'(bus.almful), 64'd0);
    beat(1'b1, 1'b0, 2'b11, 24'hABCDEF, 2'b10, 2'b11, 36'hFFFF, 2'b11, 1'b1);
    wait_out("mismatch_a", 4'b0011, 4'b0010, 60'hABCDEF);
    chk("mismatch_err", 64'(bus.mismatch_err), 64'd1);
    cycles(3);
    beat(1'b0, 1'b1, 2'b11, 24'hFFFFFF, 2'b11, 2'b01, 36'h12345678, 2'b10, 1'b1);
    wait_out("mismatch_b", 4'b0100, 4'b1000, 60'h12345678);
    cycles(3);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 12; i++) rand_beat(i < 8);
    cycles(4);
    chk("ovf_set", 64'(bus.overflow_err), 64'd1);
    chk("ovf_almful", 64'(bus.almful), 64'd1);
    drain("ovf_drain");
    bus.out_ready = 1'b0;
    repeat (6) rand_beat(1'b0);
    cycles(4);
    chk("pre_rst_almful", 64'(bus.almful), 64'd1);
    chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_almful", 64'(bus.almful), 64'd0);
    chk("async_rst_mismatch", 64'(bus.mismatch_err), 64'd0);
    chk("async_rst_overflow", 64'(bus.overflow_err), 64'd0);
    chk("async_rst_data", 64'(bus.out_logb_data), 64'd0);
    q.delete();
    cycles(2);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    cycles(1);
    chk("post_rst_empty", 64'(bus.out_valid), 64'd0);
    cycles(3);
    chk("post_rst_idle", 64'(bus.out_valid), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
